// File: rtl/dma_addr_gen_if.sv
// Memory-side bus of the DMA address generator: request/qualifier/address/write data
// flow out from the generator, the completion strobe and read data flow back in.
interface dma_addr_gen_if;
    logic [15:0] addr;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output addr,
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  addr,
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dma_addr_gen.sv
// 2-D DMA address generator with a single-outstanding memory cycle FSM,
// read-modify-write tracking and a sticky protocol error flag.
module dma_addr_gen (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [2:0]           adctlb,
    input  logic [15:0]          cfg_base,
    input  logic [7:0]           cfg_xcnt,
    input  logic [7:0]           cfg_ycnt,
    input  logic [15:0]          cfg_ystride,
    input  logic                 cfg_rmw,
    dma_addr_gen_if.master       bus,
    output logic                 xskip,
    output logic                 yskip,
    output logic                 page,
    output logic                 rmwb,
    output logic                 busy,
    output logic                 err
);

    localparam logic [2:0] C_HOLD  = 3'd0;
    localparam logic [2:0] C_LOAD  = 3'd1;
    localparam logic [2:0] C_XSTEP = 3'd2;
    localparam logic [2:0] C_YSTEP = 3'd3;
    localparam logic [2:0] C_READ  = 3'd4;
    localparam logic [2:0] C_WRITE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] addr_r, addr_s;
    logic [15:0] rowbase_r, rowbase_s;
    logic [7:0]  xrem_r, xrem_s;
    logic [7:0]  yrem_r, yrem_s;
    logic [7:0]  data_r, data_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic        rmwb_r, rmwb_s;
    logic        err_r, err_s;
    logic [2:0]  code_s;
    logic [15:0] next_row_s;

    // Next-state and next-register computation for the address datapath and memory FSM.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        rowbase_s  = rowbase_r;
        xrem_s     = xrem_r;
        yrem_s     = yrem_r;
        data_s     = data_r;
        mem_req_s  = mem_req_r;
        mem_we_s   = mem_we_r;
        rmwb_s     = rmwb_r;
        err_s      = err_r;
        code_s     = ~adctlb;
        next_row_s = rowbase_r + cfg_ystride;

        case (state_r)
            ST_IDLE: begin
                case (code_s)
                    C_HOLD: begin
                        state_s = ST_IDLE;
                    end
                    C_LOAD: begin
                        addr_s    = cfg_base;
                        rowbase_s = cfg_base;
                        xrem_s    = cfg_xcnt;
                        yrem_s    = cfg_ycnt;
                        // A LOAD in the middle of an RMW pair is flagged but still performed.
                        if (!rmwb_r) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = err_r;
                        end
                    end
                    C_XSTEP: begin
                        addr_s = addr_r + 16'd1;
                        if (xrem_r == 8'd0) begin
                            err_s = 1'b1;
                        end else begin
                            xrem_s = xrem_r - 8'd1;
                        end
                    end
                    C_YSTEP: begin
                        rowbase_s = next_row_s;
                        addr_s    = next_row_s;
                        xrem_s    = cfg_xcnt;
                        if (yrem_r == 8'd0) begin
                            err_s = 1'b1;
                        end else begin
                            yrem_s = yrem_r - 8'd1;
                        end
                    end
                    C_READ: begin
                        state_s   = ST_RD_WAIT;
                        mem_req_s = 1'b1;
                        mem_we_s  = 1'b0;
                        if (cfg_rmw) begin
                            rmwb_s = 1'b0;
                        end else begin
                            rmwb_s = rmwb_r;
                        end
                    end
                    C_WRITE: begin
                        state_s   = ST_WR_WAIT;
                        mem_req_s = 1'b1;
                        mem_we_s  = 1'b1;
                    end
                    default: begin
                        err_s = 1'b1;
                    end
                endcase
            end
            ST_RD_WAIT: begin
                if (code_s != C_HOLD) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (bus.mem_ack) begin
                    data_s    = bus.mem_rdata;
                    mem_req_s = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (code_s != C_HOLD) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (bus.mem_ack) begin
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    rmwb_s    = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_WR_WAIT;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                mem_we_s  = 1'b0;
                err_s     = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops any outstanding request.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r   <= ST_IDLE;
            addr_r    <= 16'd0;
            rowbase_r <= 16'd0;
            xrem_r    <= 8'd0;
            yrem_r    <= 8'd0;
            data_r    <= 8'd0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            rmwb_r    <= 1'b1;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            rowbase_r <= rowbase_s;
            xrem_r    <= xrem_s;
            yrem_r    <= yrem_s;
            data_r    <= data_s;
            mem_req_r <= mem_req_s;
            mem_we_r  <= mem_we_s;
            rmwb_r    <= rmwb_s;
            err_r     <= err_s;
        end
    end

    assign bus.addr      = addr_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_wdata = data_r;
    assign xskip         = (xrem_r == 8'd0);
    assign yskip         = (yrem_r == 8'd0);
    assign page          = (addr_r[7:0] == 8'hFF);
    assign rmwb          = rmwb_r;
    assign busy          = (state_r != ST_IDLE);
    assign err           = err_r;

endmodule

// File: tb/tb_dma_addr_gen.sv
// Directed bench for dma_addr_gen: linear sequence of steps with hand-computed expectations.
module tb_dma_addr_gen;

    logic        clk;
    logic        rstb;
    logic [2:0]  adctlb;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_xcnt;
    logic [7:0]  cfg_ycnt;
    logic [15:0] cfg_ystride;
    logic        cfg_rmw;
    logic        xskip, yskip, page, rmwb, busy, err;
    int          n_cmp;
    int          n_bad;

    dma_addr_gen_if bus_if ();

    dma_addr_gen dut (
        .clk         (clk),
        .rstb        (rstb),
        .adctlb      (adctlb),
        .cfg_base    (cfg_base),
        .cfg_xcnt    (cfg_xcnt),
        .cfg_ycnt    (cfg_ycnt),
        .cfg_ystride (cfg_ystride),
        .cfg_rmw     (cfg_rmw),
        .bus         (bus_if.master),
        .xskip       (xskip),
        .yskip       (yskip),
        .page        (page),
        .rmwb        (rmwb),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply code c (inverted onto adctlb) for one rising edge, then settle.
    task automatic step(input logic [2:0] c);
        adctlb = ~c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        step(3'd0);
        rstb = 1'b1;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rstb           = 1'b0;
        adctlb         = 3'b111;
        cfg_base       = 16'h10FE;
        cfg_xcnt       = 8'd2;
        cfg_ycnt       = 8'd1;
        cfg_ystride    = 16'h0040;
        cfg_rmw        = 1'b0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 8'h00;

        // Reset with garbage code applied: inputs must be ignored.
        adctlb = 3'b110;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstb = 1'b1;
        chk("rst_addr",  bus_if.addr, 32'h0);
        chk("rst_xskip", xskip, 32'd1);
        chk("rst_yskip", yskip, 32'd1);
        chk("rst_page",  page, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        chk("rst_req",   bus_if.mem_req, 32'd0);
        chk("rst_rmwb",  rmwb, 32'd1);
        chk("rst_err",   err, 32'd0);

        // LOAD then two XSTEPs across the page boundary.
        step(3'd1);
        chk("load_addr",  bus_if.addr, 32'h10FE);
        chk("load_xskip", xskip, 32'd0);
        chk("load_yskip", yskip, 32'd0);
        chk("load_page",  page, 32'd0);
        step(3'd2);
        chk("x1_addr", bus_if.addr, 32'h10FF);
        chk("x1_page", page, 32'd1);
        chk("x1_xskip", xskip, 32'd0);
        step(3'd2);
        chk("x2_addr",  bus_if.addr, 32'h1100);
        chk("x2_xskip", xskip, 32'd1);
        chk("x2_page",  page, 32'd0);
        chk("x2_err",   err, 32'd0);

        // YSTEP from rowbase 10FE, then YSTEP past the last row.
        step(3'd3);
        chk("y1_addr",  bus_if.addr, 32'h113E);
        chk("y1_xskip", xskip, 32'd0);
        chk("y1_yskip", yskip, 32'd1);
        chk("y1_err",   err, 32'd0);
        step(3'd3);
        chk("y2_addr", bus_if.addr, 32'h117E);
        chk("y2_err",  err, 32'd1);
        step(3'd0);
        chk("err_sticky", err, 32'd1);

        // RMW read then write.
        do_reset();
        cfg_rmw = 1'b1;
        step(3'd1);
        step(3'd4);
        chk("rd_req",  bus_if.mem_req, 32'd1);
        chk("rd_we",   bus_if.mem_we, 32'd0);
        chk("rd_rmwb", rmwb, 32'd0);
        chk("rd_busy", busy, 32'd1);
        step(3'd0);
        step(3'd0);
        chk("rd_hold_req",  bus_if.mem_req, 32'd1);
        chk("rd_hold_addr", bus_if.addr, 32'h10FE);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 8'hA5;
        step(3'd0);
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 8'h00;
        chk("rdack_req",  bus_if.mem_req, 32'd0);
        chk("rdack_busy", busy, 32'd0);
        chk("rdack_rmwb", rmwb, 32'd0);
        step(3'd5);
        chk("wr_req",   bus_if.mem_req, 32'd1);
        chk("wr_we",    bus_if.mem_we, 32'd1);
        chk("wr_wdata", bus_if.mem_wdata, 32'hA5);
        bus_if.mem_ack = 1'b1;
        step(3'd0);
        bus_if.mem_ack = 1'b0;
        chk("wrack_rmwb", rmwb, 32'd1);
        chk("wrack_req",  bus_if.mem_req, 32'd0);
        chk("wrack_we",   bus_if.mem_we, 32'd0);
        chk("wrack_err",  err, 32'd0);
        // Stray ack in IDLE is ignored.
        bus_if.mem_ack = 1'b1;
        step(3'd0);
        bus_if.mem_ack = 1'b0;
        chk("idle_ack_err",  err, 32'd0);
        chk("idle_ack_busy", busy, 32'd0);

        // LOAD while an RMW pair is open.
        step(3'd4);
        bus_if.mem_ack = 1'b1;
        step(3'd0);
        bus_if.mem_ack = 1'b0;
        cfg_base = 16'h2000;
        step(3'd1);
        chk("rmwload_err",  err, 32'd1);
        chk("rmwload_rmwb", rmwb, 32'd0);
        chk("rmwload_addr", bus_if.addr, 32'h2000);

        // XSTEP while a read is outstanding.
        do_reset();
        cfg_rmw  = 1'b0;
        cfg_base = 16'h10FE;
        step(3'd1);
        step(3'd4);
        step(3'd2);
        chk("busyx_addr", bus_if.addr, 32'h10FE);
        chk("busyx_err",  err, 32'd1);
        chk("busyx_req",  bus_if.mem_req, 32'd1);
        chk("busyx_xskip", xskip, 32'd0);
        step(3'd0);
        chk("busyx_req2", bus_if.mem_req, 32'd1);
        bus_if.mem_ack = 1'b1;
        step(3'd0);
        bus_if.mem_ack = 1'b0;
        chk("busyx_ackreq", bus_if.mem_req, 32'd0);

        // Reset during WR_WAIT with an RMW pair open.
        do_reset();
        cfg_rmw = 1'b1;
        step(3'd1);
        step(3'd4);
        bus_if.mem_ack = 1'b1;
        step(3'd0);
        bus_if.mem_ack = 1'b0;
        step(3'd5);
        chk("pre_rst_busy", busy, 32'd1);
        chk("pre_rst_rmwb", rmwb, 32'd0);
        rstb = 1'b0;
        step(3'd0);
        rstb = 1'b1;
        chk("midrst_req",  bus_if.mem_req, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_rmwb", rmwb, 32'd1);
        chk("midrst_addr", bus_if.addr, 32'h0);
        bus_if.mem_ack = 1'b1;
        step(3'd0);
        bus_if.mem_ack = 1'b0;
        chk("lateack_err",  err, 32'd0);
        chk("lateack_busy", busy, 32'd0);

        // Reserved code 7 (adctlb=000).
        cfg_rmw  = 1'b0;
        cfg_base = 16'h1234;
        cfg_xcnt = 8'd5;
        cfg_ycnt = 8'd3;
        step(3'd1);
        step(3'd7);
        chk("c7_err",   err, 32'd1);
        chk("c7_addr",  bus_if.addr, 32'h1234);
        chk("c7_xskip", xskip, 32'd0);
        chk("c7_yskip", yskip, 32'd0);
        chk("c7_busy",  busy, 32'd0);
        chk("c7_req",   bus_if.mem_req, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_addr_gen.md
DMA_ADDR_GEN -- requirements
Module: dma_addr_gen

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge clock) and rstb input 1 (synchronous active-low reset).
REQ-002 The module SHALL have the following inputs, each with no default:
- adctlb, 3 bits: active-low address-control code; code c = ~adctlb.
- cfg_base, 16 bits: block start address.
- cfg_xcnt, 8 bits: elements per row minus 1.
- cfg_ycnt, 8 bits: rows minus 1.
- cfg_ystride, 16 bits: row-to-row address increment.
- cfg_rmw, 1 bit: read-modify-write mode enable.
- mem_ack, 1 bit: memory completion strobe.
- mem_rdata, 8 bits: read data, valid with mem_ack.
REQ-003 The module SHALL have the following outputs:
- addr, 16 bits: current address.
- mem_req, 1 bit: memory request.
- mem_we, 1 bit: write qualifier.
- mem_wdata, 8 bits: write data, equal to the data register.
- xskip, 1 bit: the current element is the last in its row.
- yskip, 1 bit: the current row is the last.
- page, 1 bit: the next X step crosses a 256-byte page.
- rmwb, 1 bit: active-low RMW-in-progress flag.
- busy, 1 bit: a memory cycle is outstanding.
- err, 1 bit: sticky protocol error.

Function
REQ-004 Decoding of c, sampled every clk edge while rstb=1, SHALL be:
- 0 = HOLD.
- 1 = LOAD.
- 2 = XSTEP.
- 3 = YSTEP.
- 4 = READ.
- 5 = WRITE.
- 6 and 7 SHALL be treated as HOLD and SHALL set err.
REQ-005 LOAD SHALL set addr<=cfg_base, rowbase<=cfg_base, xrem<=cfg_xcnt and yrem<=cfg_ycnt in one cycle.
REQ-006 XSTEP SHALL set addr<=addr+1 (mod 2^16) and xrem<=xrem-1. When xrem==0, XSTEP SHALL leave xrem at 0 and set err, while addr still increments.
REQ-007 YSTEP SHALL set rowbase<=rowbase+cfg_ystride (mod 2^16), addr<=rowbase+cfg_ystride, xrem<=cfg_xcnt and yrem<=yrem-1. When yrem==0, YSTEP SHALL leave yrem at 0 and set err, while the address update still occurs.
REQ-008 The status outputs SHALL be combinational from the registers: xskip=(xrem==0), yskip=(yrem==0), page=(addr[7:0]==8'hFF).
REQ-009 The memory FSM SHALL have the states IDLE, RD_WAIT and WR_WAIT, with busy=1 exactly when the state is not IDLE.
REQ-010 READ in IDLE SHALL move the FSM to RD_WAIT on the next edge, with mem_req=1 and mem_we=0 registered.
REQ-011 WRITE in IDLE SHALL move the FSM to WR_WAIT, with mem_req=1 and mem_we=1.
REQ-012 In RD_WAIT, mem_ack=1 SHALL capture mem_rdata into the data register, clear mem_req, and return the FSM to IDLE on the same edge.
REQ-013 In WR_WAIT, mem_ack=1 SHALL clear mem_req and mem_we and return the FSM to IDLE.
REQ-014 mem_req SHALL stay asserted without limit until mem_ack, and addr SHALL be stable while busy=1.
REQ-015 Any code other than HOLD received while busy=1 SHALL be ignored, with no register change except err<=1.
REQ-016 mem_ack while in IDLE SHALL be ignored and SHALL NOT set err.
REQ-017 rmwb SHALL go 0 on the edge that accepts READ when cfg_rmw=1, and SHALL return to 1 on the edge where a WR_WAIT mem_ack is received. A LOAD while rmwb=0 SHALL set err and leave rmwb unchanged.
REQ-018 Once set, err SHALL clear only by reset.

Reset
REQ-019 When rstb=0 at a clk edge, the module SHALL set:
- addr, rowbase, xrem and yrem to 0;
- the data register to 0;
- the FSM to IDLE;
- mem_req, mem_we, busy and err to 0;
- rmwb to 1.
This applies even mid-cycle: an outstanding request SHALL be dropped on that edge.
REQ-020 Right after reset, the status outputs SHALL read xskip=1, yskip=1 and page=0.
REQ-021 Inputs SHALL be ignored while rstb=0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- LOAD with cfg_base=16'h10FE, xcnt=2, ycnt=1 -> addr=10FE, xskip=0, yskip=0, page=0. Then XSTEP -> addr=10FF, page=1. Then XSTEP -> addr=1100, xskip=1, page=0.
- Continuing from the first scenario, with cfg_ystride=16'h0040 -> YSTEP gives addr=113E, xrem=2, yskip=1. A further YSTEP sets err=1 and gives addr=117E.
- cfg_rmw=1: READ -> next cycle mem_req=1, mem_we=0, rmwb=0. mem_ack after 3 cycles with rdata=8'hA5 -> mem_req=0, busy=0. WRITE -> mem_we=1, mem_wdata=A5. mem_ack -> rmwb=1.
- READ then XSTEP while busy -> addr unchanged, err=1, mem_req still 1 until mem_ack.
- rstb=0 for one edge during WR_WAIT -> mem_req=0, busy=0, rmwb=1, addr=0 on that edge. A later mem_ack is ignored and err stays 0.
- adctlb=3'b000 (c=7) -> no state change except err=1.
